// File: rtl/rv32_pkg.sv
// Shared encodings for the R-type-only RV32I core: opcode/funct constants and ALU operations.
package rv32_pkg;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_NOP
  } alu_op_t;

endpackage

// File: rtl/rv32_alu_if.sv
// Operand/result bundle between the decode stage and the ALU.
interface rv32_alu_if;
  import rv32_pkg::*;

  logic [31:0] a;
  logic [31:0] b;
  alu_op_t     op;
  logic [31:0] result;

  modport master (output a, output b, output op, input  result);
  modport slave  (input  a, input  b, input  op, output result);
endinterface

// File: rtl/rv32_alu.sv
// Combinational 32-bit ALU covering the RV32I OP-class operations.
module rv32_alu
  import rv32_pkg::*;
(
  rv32_alu_if.slave bus
);

  logic [4:0] sh;
  assign sh = bus.b[4:0];

  // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
  always_comb begin
    bus.result = '0;
    unique case (bus.op)
      ALU_ADD:  bus.result = bus.a + bus.b;
      ALU_SUB:  bus.result = bus.a - bus.b;
      ALU_SLL:  bus.result = bus.a << sh;
      ALU_SLT:  bus.result = {31'b0, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: bus.result = {31'b0, bus.a < bus.b};
      ALU_XOR:  bus.result = bus.a ^ bus.b;
      ALU_SRL:  bus.result = bus.a >> sh;
      ALU_SRA:  bus.result = $unsigned($signed(bus.a) >>> sh);
      ALU_OR:   bus.result = bus.a | bus.b;
      ALU_AND:  bus.result = bus.a & bus.b;
      default:  bus.result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_soc.sv
// Single-cycle RV32I core executing only OP-class instructions: PC, ROM, decoder, regfile, ALU.
module rv32_soc
  import rv32_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input logic clk,
  input logic reset
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic [31:0] instr;

  // ROM is pre-filled with zeros at elaboration; its image is placed by the environment.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0;
  end

  assign instr = imem[pc[IDX_W+1:2]];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  alu_op_t alu_op;
  logic    reg_we;

  always_comb begin
    alu_op = ALU_NOP;
    if (opcode == OPC_OP) begin
      if (f7 == F7_BASE) begin
        unique case (f3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SRL_SRA: alu_op = ALU_SRL;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    alu_op = ALU_NOP;
        endcase
      end else if (f7 == F7_ALT) begin
        if (f3 == F3_ADD_SUB)      alu_op = ALU_SUB;
        else if (f3 == F3_SRL_SRA) alu_op = ALU_SRA;
      end
    end
  end

  assign reg_we = (alu_op != ALU_NOP) && (rd != 5'd0);

  rv32_alu_if alu_bus ();

  assign alu_bus.a  = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign alu_bus.b  = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign alu_bus.op = alu_op;

  rv32_alu u_alu (.bus(alu_bus.slave));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the register file is reset on purpose (regs[i] = i), which keeps it out of block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else begin
      pc <= pc + 32'd4;
      if (reg_we) regs[rd] <= alu_bus.result;
    end
  end

endmodule

// File: tb/tb_rv32_soc.sv
// Bring-up bench for rv32_soc: directed program table, wrap/reset sequence, random programs vs model.
module tb_rv32_soc;
  import rv32_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv32_soc #(.IMEM_DEPTH(DEPTH), .IMEM_FILE("")) dut (.clk(clk), .reset(reset));

  // Standalone ALU on its own interface for corner-case operand vectors.
  rv32_alu_if alu_bus ();
  rv32_alu u_alu (.bus(alu_bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OPC_OP};
  endfunction

  // Reference model: architectural state plus an instruction interpreter written from the ISA rules.
  logic [31:0] rom    [DEPTH];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, r;
    int          rd, sh;
    bit          wr;
    ins = rom[(m_pc / 4) % DEPTH];
    rd  = int'(ins[11:7]);
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    sh  = int'(b % 32);
    wr  = 1'b1;
    r   = 0;
    if (ins[6:0] != 7'b0110011) wr = 1'b0;
    else if (ins[31:25] == 7'b0000000) begin
      case (ins[14:12])
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
        3'd3: r = (a < b) ? 1 : 0;
        3'd4: r = a ^ b;
        3'd5: r = a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'd0) r = a - b;
    else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'd5) r = $unsigned($signed(a) >>> sh);
    else wr = 1'b0;
    if (wr && rd != 0) m_regs[rd] = r;
    m_pc = m_pc + 4;
  endtask

  task automatic load_rom();
    for (int i = 0; i < DEPTH; i++) dut.imem[i] = rom[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_state(input string tag);
    int k;
    k = 31;
    for (int i = 31; i >= 0; i--) if (dut.regs[i] !== m_regs[i]) k = i;
    check({tag, " pc"}, dut.pc, m_pc);
    check($sformatf("%s x%0d", tag, k), dut.regs[k], m_regs[k]);
  endtask

  typedef struct {
    logic [31:0] instr;
    int          chk_reg;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  vec_t     vecs [16];
  alu_vec_t avec [11];

  initial begin
    vecs[0]  = '{rtype(F7_BASE, 2, 1, F3_ADD_SUB, 3),  3,  32'h00000003};
    vecs[1]  = '{rtype(F7_ALT,  2, 1, F3_ADD_SUB, 4),  4,  32'hFFFFFFFF};
    vecs[2]  = '{rtype(F7_ALT,  1, 4, F3_SRL_SRA, 5),  5,  32'hFFFFFFFF};
    vecs[3]  = '{rtype(F7_BASE, 31, 4, F3_SRL_SRA, 6), 6,  32'h00000001};
    vecs[4]  = '{rtype(F7_BASE, 1, 4, F3_SLT, 7),      7,  32'h00000001};
    vecs[5]  = '{rtype(F7_BASE, 1, 4, F3_SLTU, 8),     8,  32'h00000000};
    vecs[6]  = '{rtype(F7_BASE, 31, 1, F3_SLL, 9),     9,  32'h80000000};
    vecs[7]  = '{rtype(F7_BASE, 2, 1, F3_ADD_SUB, 0),  0,  32'h00000000};
    vecs[8]  = '{rtype(F7_BASE, 3, 0, F3_XOR, 10),     10, 32'h00000003};
    vecs[9]  = '{rtype(F7_BASE, 7, 6, F3_AND, 11),     11, 32'h00000001};
    vecs[10] = '{rtype(F7_BASE, 4, 2, F3_OR, 12),      12, 32'hFFFFFFFF};
    vecs[11] = '{32'h00000013,                         0,  32'h00000000};
    vecs[12] = '{32'h00000000,                         0,  32'h00000000};
    vecs[13] = '{rtype(F7_ALT, 2, 1, F3_SLL, 13),      13, 32'h0000000D};
    vecs[14] = '{32'h00508713,                         14, 32'h0000000E};
    vecs[15] = '{rtype(7'b0000001, 2, 1, F3_ADD_SUB, 15), 15, 32'h0000000F};

    avec[0]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    avec[1]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    avec[2]  = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002};
    avec[3]  = '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001};
    avec[4]  = '{ALU_SLTU, 32'h80000000, 32'h00000001, 32'h00000000};
    avec[5]  = '{ALU_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
    avec[6]  = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001};
    avec[7]  = '{ALU_XOR,  32'hF0F0AAAA, 32'h0FF05555, 32'hFF00FFFF};
    avec[8]  = '{ALU_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F};
    avec[9]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    avec[10] = '{ALU_NOP,  32'h12345678, 32'h9ABCDEF0, 32'h00000000};

    #2;
    foreach (avec[i]) begin
      alu_bus.a  = avec[i].a;
      alu_bus.b  = avec[i].b;
      alu_bus.op = avec[i].op;
      #1;
      check($sformatf("alu %s", avec[i].op.name()), alu_bus.result, avec[i].exp);
    end

    // Directed program: table entries first, the rest of the ROM zero.
    for (int i = 0; i < DEPTH; i++) rom[i] = (i < 16) ? vecs[i].instr : 32'h0;
    load_rom();

    reset = 1'b0;
    tick();
    tick();
    check("reset pc", dut.pc, 32'h0);
    check("reset x0", dut.regs[0], 32'h0);
    check("reset x5", dut.regs[5], 32'd5);
    check("reset x31", dut.regs[31], 32'd31);

    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("vec%0d pc", i), dut.pc, 32'(4 * (i + 1)));
      check($sformatf("vec%0d x%0d", i, vecs[i].chk_reg), dut.regs[vecs[i].chk_reg], vecs[i].exp);
    end

    // Fetch index wraps after DEPTH words; then a mid-program reset reinitialises state.
    for (int i = 16; i < DEPTH; i++) tick();
    check("wrap pc", dut.pc, 32'(4 * DEPTH));
    check("wrap fetch", dut.instr, vecs[0].instr);
    tick();
    check("wrap x3", dut.regs[3], 32'd3);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    check("midreset pc", dut.pc, 32'h0);
    check("midreset x3", dut.regs[3], 32'd3);
    check("midreset x4", dut.regs[4], 32'd4);
    check("midreset x12", dut.regs[12], 32'd12);

    // Random programs: mostly legal OP encodings, some arbitrary words.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(9) < 8) begin
          logic [6:0] f7;
          logic [2:0] f3;
          f3 = 3'($urandom_range(7));
          case ($urandom_range(3))
            0:       f7 = F7_ALT;
            1:       f7 = 7'($urandom);
            default: f7 = F7_BASE;
          endcase
          rom[i] = rtype(f7, $urandom_range(31), $urandom_range(31), f3, $urandom_range(31));
        end else begin
          rom[i] = $urandom;
        end
      end
      load_rom();
      reset = 1'b0;
      tick();
      model_reset();
      reset = 1'b1;
      for (int c = 0; c < 150; c++) begin
        reset = (c == 100) ? 1'b0 : 1'b1;
        tick();
        if (c == 100) model_reset();
        else model_step();
        compare_state($sformatf("rnd%0d.%0d", round, c));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
